// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring), one result every 34 cycles.
// The divider datapath and DIV state are built only when MULTDIV_DIV_EN is defined.
module multdiv_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
`ifdef MULTDIV_DIV_EN
      DIV  = 2'd2,
`endif
      DONE = 2'd3
   } state_t;

   state_t             state_q;
   logic [4:0]         cnt_q;
   logic               last_q;
   logic [31:0]        result_q;
   logic               exc_q;
   logic               rdy_q;
   logic               busy_q;

   logic signed [31:0] a_q;
   logic [64:0]        p_q;
   logic [64:0]        p_d;

   // One Booth step; the 33-bit accumulator keeps the sign when the multiplicand is 0x80000000.
   function automatic logic [64:0] booth_step(input logic [64:0] p, input logic signed [31:0] m);
      logic signed [32:0] acc;
      acc = {p[64], p[64:33]};
      case (p[1:0])
         2'b01:   acc = acc + {m[31], m};
         2'b10:   acc = acc - {m[31], m};
         default: acc = acc;
      endcase
      return {acc, p[32:1]};
   endfunction

   // Product bits [63:31] must all match for the low word to represent the full product.
   function automatic logic mul_overflow(input logic [32:0] hi);
      return !((&hi) || !(|hi));
   endfunction

   assign p_d = booth_step(p_q, a_q);

`ifdef MULTDIV_DIV_EN
   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dvs_q;
   logic        neg_q;
   logic        dz_q;
   logic [32:0] rem_full;
   logic [31:0] trial;
   logic        ge;
   logic [31:0] rem_d;
   logic [31:0] quo_d;
   logic [32:0] div_out;

   function automatic logic [31:0] abs32(input logic [31:0] x);
      return x[31] ? (~x + 32'd1) : x;
   endfunction

   // Returns {exception, quotient}; only |A|=2^31 with a positive sign overflows.
   function automatic logic [32:0] div_fix(input logic [31:0] q, input logic neg, input logic dz);
      logic [32:0] r;
      if (dz) r = {1'b1, 32'd0};
      else    r = {!neg && q[31], neg ? (~q + 32'd1) : q};
      return r;
   endfunction

   always_comb begin
      rem_full = {rem_q, quo_q[31]};
      ge       = (rem_full >= {1'b0, dvs_q});
      trial    = rem_full[31:0] - dvs_q;
      rem_d    = ge ? trial : rem_full[31:0];
      quo_d    = {quo_q[30:0], ge};
   end

   assign div_out = div_fix(quo_q, neg_q, dz_q);
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         last_q   <= 1'b0;
         result_q <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               rdy_q   <= 1'b0;
               state_q <= IDLE;
               if (ctrl_MULT) begin
                  a_q     <= data_operandA;
                  p_q     <= {32'd0, data_operandB, 1'b0};
                  cnt_q   <= '0;
                  last_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= MULT;
               end else if (ctrl_DIV) begin
`ifdef MULTDIV_DIV_EN
                  rem_q   <= '0;
                  quo_q   <= abs32(data_operandA);
                  dvs_q   <= abs32(data_operandB);
                  neg_q   <= data_operandA[31] ^ data_operandB[31];
                  dz_q    <= ~|data_operandB;
                  cnt_q   <= '0;
                  last_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= DIV;
`else
                  result_q <= '0;
                  exc_q    <= 1'b1;
                  rdy_q    <= 1'b1;
                  state_q  <= DONE;
`endif
               end
            end
            MULT: begin
               if (last_q) begin
                  result_q <= p_q[32:1];
                  exc_q    <= mul_overflow(p_q[64:32]);
                  rdy_q    <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= DONE;
               end else begin
                  p_q    <= p_d;
                  cnt_q  <= cnt_q + 5'd1;
                  last_q <= (cnt_q == 5'd31);
               end
            end
`ifdef MULTDIV_DIV_EN
            DIV: begin
               if (last_q) begin
                  result_q <= div_out[31:0];
                  exc_q    <= div_out[32];
                  rdy_q    <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= DONE;
               end else begin
                  rem_q  <= rem_d;
                  quo_q  <= quo_d;
                  cnt_q  <= cnt_q + 5'd1;
                  last_q <= (cnt_q == 5'd31);
               end
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: random and corner operands against an arithmetic reference.
module tb_multdiv_unit;
   logic        clock = 1'b0;
   logic        reset;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam int MUL_LAT = 33;
`ifdef MULTDIV_DIV_EN
   localparam int DIV_LAT = 33;
`else
   localparam int DIV_LAT = 0;
`endif

   always #5 clock = ~clock;

   multdiv_unit dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   // Reference: {exception, result} from plain 64-bit signed arithmetic.
   function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      longint      p;
      logic [31:0] lo;
      p  = longint'($signed(a)) * longint'($signed(b));
      lo = p[31:0];
      return {p != longint'($signed(lo)), lo};
   endfunction

   function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] r;
`ifdef MULTDIV_DIV_EN
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      if (sb == 0)                                   r = {1'b1, 32'd0};
      else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {1'b1, 32'h80000000};
      else                                           r = {1'b0, 32'(sa / sb)};
`else
      r = {1'b1, 32'd0 & (a ^ b)};
`endif
      return r;
   endfunction

   // Call at a negedge; returns at the negedge following the start edge.
   task automatic pulse_start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      data_operandA = a;
      data_operandB = b;
      @(negedge clock);
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   // Counts negedge samples (0 = right after the start edge) until RDY, bounded by limit.
   task automatic await_rdy(input int limit, output int k, output bit busy_all);
      k        = 0;
      busy_all = 1'b1;
      while (data_resultRDY !== 1'b1 && k < limit) begin
         if (busy !== 1'b1) busy_all = 1'b0;
         @(negedge clock);
         k++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      data_operandA = $urandom; data_operandB = $urandom;
      repeat (3) @(negedge clock);
      n_cmp++; if (data_result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", data_result); end
      n_cmp++; if (data_exception !== 1'b0) begin n_fail++; $display("FAIL reset_exc: got %b want 0", data_exception); end
      n_cmp++; if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b want 0", data_resultRDY); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      reset = 1'b0;
   endtask

   task automatic test_mult_directed();
      logic [31:0] ta [6] = '{32'd7, 32'h00010000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
      logic [31:0] tbv[6] = '{32'hFFFFFFFD, 32'h00010000, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h7FFFFFFF};
      logic [32:0] exp;
      int k;
      bit ba;
      for (int i = 0; i < 6; i++) begin
         exp = ref_mul(ta[i], tbv[i]);
         // The last case raises both starts together; the multiply must win.
         pulse_start(1'b1, i == 5, ta[i], tbv[i]);
         await_rdy(40, k, ba);
         n_cmp++; if (k !== MUL_LAT) begin n_fail++; $display("FAIL mdir%0d_latency: got %0d want %0d", i, k, MUL_LAT); end
         n_cmp++; if (data_result !== exp[31:0]) begin n_fail++; $display("FAIL mdir%0d_result: got %h want %h", i, data_result, exp[31:0]); end
         n_cmp++; if (data_exception !== exp[32]) begin n_fail++; $display("FAIL mdir%0d_exc: got %b want %b", i, data_exception, exp[32]); end
         n_cmp++; if (ba !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mdir%0d_busy: got %b/%b want 1/0", i, ba, busy); end
         @(negedge clock);
         n_cmp++; if (data_resultRDY !== 1'b0 || data_result !== exp[31:0]) begin
            n_fail++; $display("FAIL mdir%0d_hold: got rdy %b res %h want 0 %h", i, data_resultRDY, data_result, exp[31:0]);
         end
      end
   endtask

   task automatic test_mult_random();
      logic [31:0] a, b;
      logic [32:0] exp;
      int k;
      bit ba;
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         b = $urandom;
         if (i % 2 == 0) begin
            a = $urandom_range(0, 65535);
            b = $urandom_range(0, 65535);
            if (i % 4 == 0) a = -a;
            if (i % 8 == 2) b = -b;
         end
         exp = ref_mul(a, b);
         pulse_start(1'b1, 1'b0, a, b);
         await_rdy(40, k, ba);
         n_cmp++; if (k !== MUL_LAT) begin n_fail++; $display("FAIL mrnd%0d_latency: got %0d want %0d", i, k, MUL_LAT); end
         n_cmp++; if (data_result !== exp[31:0]) begin n_fail++; $display("FAIL mrnd%0d_result: A=%h B=%h got %h want %h", i, a, b, data_result, exp[31:0]); end
         n_cmp++; if (data_exception !== exp[32]) begin n_fail++; $display("FAIL mrnd%0d_exc: A=%h B=%h got %b want %b", i, a, b, data_exception, exp[32]); end
      end
      @(negedge clock);
   endtask

   task automatic test_div();
      logic [31:0] da[8] = '{32'hFFFFFF9C, 32'hFFFFFF9C, 32'h80000000, 32'd100, 32'd7, 32'h80000000, 32'h7FFFFFFF, 32'd0};
      logic [31:0] db[8] = '{32'd7, 32'd0, 32'hFFFFFFFF, 32'd10, 32'hFFFFFF9C, 32'd1, 32'hFFFFFFFE, 32'd5};
      logic [31:0] a, b;
      logic [32:0] exp;
      int k;
      bit ba;
      for (int i = 0; i < 18; i++) begin
         if (i < 8) begin
            a = da[i];
            b = db[i];
         end else begin
            a = $urandom;
            b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i % 3 == 0) b = -b;
         end
         exp = ref_div(a, b);
         pulse_start(1'b0, 1'b1, a, b);
         await_rdy(40, k, ba);
         n_cmp++; if (k !== DIV_LAT) begin n_fail++; $display("FAIL div%0d_latency: got %0d want %0d", i, k, DIV_LAT); end
         n_cmp++; if (data_result !== exp[31:0]) begin n_fail++; $display("FAIL div%0d_result: A=%h B=%h got %h want %h", i, a, b, data_result, exp[31:0]); end
         n_cmp++; if (data_exception !== exp[32]) begin n_fail++; $display("FAIL div%0d_exc: A=%h B=%h got %b want %b", i, a, b, data_exception, exp[32]); end
`ifdef MULTDIV_DIV_EN
         n_cmp++; if (ba !== 1'b1) begin n_fail++; $display("FAIL div%0d_busy: got %b want 1", i, ba); end
`endif
         n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL div%0d_busy_done: got %b want 0", i, busy); end
         @(negedge clock);
         n_cmp++; if (data_resultRDY !== 1'b0 || data_result !== exp[31:0]) begin
            n_fail++; $display("FAIL div%0d_hold: got rdy %b res %h want 0 %h", i, data_resultRDY, data_result, exp[31:0]);
         end
      end
   endtask

   task automatic test_ignore_during_busy();
      logic [31:0] a, b;
      logic [32:0] exp;
      int k;
      bit ba, early;
      a = $urandom; b = $urandom_range(0, 4000);
      exp = ref_mul(a, b);
      early = 1'b1;
      pulse_start(1'b1, 1'b0, a, b);
      for (int i = 0; i < 10; i++) begin
         if (busy !== 1'b1 || data_resultRDY !== 1'b0) early = 1'b0;
         @(negedge clock);
      end
      if (busy !== 1'b1) early = 1'b0;
      ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd10;
      @(negedge clock);
      ctrl_DIV = 1'b0; data_operandA = $urandom; data_operandB = $urandom;
      await_rdy(40, k, ba);
      n_cmp++; if (k + 11 !== MUL_LAT) begin n_fail++; $display("FAIL ignore_latency: got %0d want %0d", k + 11, MUL_LAT); end
      n_cmp++; if (data_result !== exp[31:0]) begin n_fail++; $display("FAIL ignore_result: got %h want %h", data_result, exp[31:0]); end
      n_cmp++; if (data_exception !== exp[32]) begin n_fail++; $display("FAIL ignore_exc: got %b want %b", data_exception, exp[32]); end
      n_cmp++; if ((early & ba) !== 1'b1) begin n_fail++; $display("FAIL ignore_busy: got %b want 1", early & ba); end
      @(negedge clock);
   endtask

   task automatic test_reset_abort();
      logic [32:0] exp;
      int k;
      bit ba, seen;
      seen = 1'b0;
      pulse_start(1'b1, 1'b0, $urandom, $urandom);
      for (int i = 0; i < 20; i++) begin
         if (data_resultRDY !== 1'b0) seen = 1'b1;
         @(negedge clock);
      end
      reset = 1'b1; ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd5;
      @(negedge clock);
      reset = 1'b0; ctrl_MULT = 1'b0;
      n_cmp++; if (seen !== 1'b0 || data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL abort_rdy: got %b want 0", seen | data_resultRDY); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
      n_cmp++; if (data_result !== 32'd0 || data_exception !== 1'b0) begin
         n_fail++; $display("FAIL abort_outputs: got %h/%b want 0/0", data_result, data_exception);
      end
      exp = ref_div(32'd100, 32'd10);
      pulse_start(1'b0, 1'b1, 32'd100, 32'd10);
      await_rdy(40, k, ba);
      n_cmp++; if (k !== DIV_LAT) begin n_fail++; $display("FAIL abort_div_latency: got %0d want %0d", k, DIV_LAT); end
      n_cmp++; if (data_result !== exp[31:0]) begin n_fail++; $display("FAIL abort_div_result: got %h want %h", data_result, exp[31:0]); end
      n_cmp++; if (data_exception !== exp[32]) begin n_fail++; $display("FAIL abort_div_exc: got %b want %b", data_exception, exp[32]); end
      @(negedge clock);
   endtask

   task automatic test_back_to_back();
      logic [31:0] a1, b1, a2, b2;
      logic [32:0] e1, e2;
      int k1, k2;
      bit ba1, ba2;
      a1 = $urandom; b1 = $urandom; a2 = $urandom_range(0, 9999); b2 = -$urandom_range(1, 9999);
      e1 = ref_mul(a1, b1);
      e2 = ref_mul(a2, b2);
      pulse_start(1'b1, 1'b0, a1, b1);
      await_rdy(40, k1, ba1);
      n_cmp++; if (k1 !== MUL_LAT || data_result !== e1[31:0]) begin
         n_fail++; $display("FAIL b2b_first: got lat %0d res %h want %0d %h", k1, data_result, MUL_LAT, e1[31:0]);
      end
      pulse_start(1'b1, 1'b0, a2, b2);
      await_rdy(40, k2, ba2);
      n_cmp++; if (k2 + 1 !== 34) begin n_fail++; $display("FAIL b2b_period: got %0d want 34", k2 + 1); end
      n_cmp++; if (data_result !== e2[31:0] || data_exception !== e2[32]) begin
         n_fail++; $display("FAIL b2b_second: got %h/%b want %h/%b", data_result, data_exception, e2[31:0], e2[32]);
      end
      n_cmp++; if (ba2 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", ba2); end
      @(negedge clock);
      n_cmp++; if (data_resultRDY !== 1'b0 || data_result !== e2[31:0]) begin
         n_fail++; $display("FAIL b2b_hold: got rdy %b res %h want 0 %h", data_resultRDY, data_result, e2[31:0]);
      end
   endtask

   initial begin
      test_reset();
      test_mult_directed();
      test_mult_random();
      test_div();
      test_ignore_during_busy();
      test_reset_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/multdiv_unit.md
MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clock and reset.
REQ-002 Port clock  input  1  rising-edge clock for all state.
REQ-003 Port reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
REQ-004 Port ctrl_MULT  input  1  start a signed multiply; single-cycle pulse.
REQ-005 Port ctrl_DIV  input  1  start a signed divide; single-cycle pulse.
REQ-006 Port data_operandA  input  32  multiplicand or dividend, two's complement.
REQ-007 Port data_operandB  input  32  multiplier or divisor, two's complement.
REQ-008 Port data_result  output  32  product (low 32 bits) or quotient; feeds the ALU result-select mux.
REQ-009 Port data_exception  output  1  overflow or divide-by-zero flag for the current result.
REQ-010 Port data_resultRDY  output  1  single-cycle pulse; data_result and data_exception are valid.
REQ-011 Port busy  output  1  high while an operation is in progress.

Function
REQ-012 The FSM SHALL have four states: IDLE, MULT, DIV and DONE; reset SHALL force IDLE.
REQ-013 In IDLE or DONE, ctrl_MULT high SHALL latch both operands on that edge, clear the 5-bit iteration counter and enter MULT.
REQ-014 In IDLE or DONE, ctrl_DIV high with ctrl_MULT low SHALL latch both operands, clear the counter and enter DIV.
REQ-015 If ctrl_MULT and ctrl_DIV are high together, the block SHALL start the multiply and ignore ctrl_DIV.
REQ-016 While in MULT or DIV, ctrl_MULT and ctrl_DIV SHALL be ignored, and operand changes SHALL have no effect.
REQ-017 MULT SHALL run 32 iterations of radix-2 Booth (one per cycle) on a 65-bit product/multiplier register.
REQ-018 DIV SHALL run 32 iterations of restoring division (one per cycle) on operand magnitudes, with sign correction applied on entry to DONE.
REQ-019 After the 32nd iteration, the FSM SHALL enter DONE for exactly one cycle; data_resultRDY SHALL be high only in DONE.
REQ-020 Latency: with start sampled at edge E, data_resultRDY SHALL be high in the cycle following edge E+33.
REQ-021 data_result and data_exception SHALL hold their DONE values until the next start is accepted or reset occurs.
REQ-022 A start accepted in DONE SHALL give back-to-back operation, with a new result every 34 cycles.
REQ-023 busy SHALL be high in MULT and DIV, and low in IDLE and DONE.
REQ-024 Multiply result SHALL be the low 32 bits of the 64-bit signed product.
REQ-025 data_exception SHALL be 1 for a multiply when bits [63:31] of the product are not all equal.
REQ-026 Divide result SHALL be the quotient truncated toward zero, and the remainder SHALL be discarded.
REQ-027 For a divisor of 0, the block SHALL return result 0 with data_exception 1, at the same 34-cycle latency.
REQ-028 For 0x80000000 / 0xFFFFFFFF, the block SHALL return result 0x80000000 with data_exception 1.

Reset
REQ-029 Reset SHALL drive data_result 0, data_exception 0, data_resultRDY 0, busy 0, counter 0 and state IDLE.
REQ-030 Reset mid-operation SHALL abort the operation with no data_resultRDY pulse, and ctrl_* SHALL be ignored on the reset edge.
REQ-031 The first start SHALL be accepted on the first edge after reset deasserts.

Configuration
REQ-032 The divider SHALL be included only when macro MULTDIV_DIV_EN is defined.
REQ-033 With MULTDIV_DIV_EN defined, the block SHALL behave exactly as REQ-014, REQ-018 and REQ-026 to REQ-028.
REQ-034 Without MULTDIV_DIV_EN, no DIV state or divider datapath SHALL exist, and ctrl_DIV accepted in IDLE or DONE SHALL go directly to DONE on the next edge.
REQ-035 In that no-divider case, the DONE cycle SHALL give data_result 0, data_exception 1 and data_resultRDY 1 (latency 1).

Verification
REQ-036 Multiply pulse with A=7, B=-3: result 0xFFFFFFEB, exception 0, and data_resultRDY exactly 34 cycles after the start edge.
REQ-037 Multiply pulse with A=0x00010000, B=0x00010000: result 0x00000000, exception 1.
REQ-038 Divide pulse with A=-100, B=7: result 0xFFFFFFF2 (-14), exception 0; with B=0: result 0, exception 1, same latency.
REQ-039 Multiply started, then ctrl_DIV pulsed 10 cycles later: the pulse is ignored, the product returns on schedule, and busy stays high until DONE.
REQ-040 Reset asserted 20 cycles into a multiply, then ctrl_DIV 100/10 started: no RDY for the aborted multiply, and result 10 arrives 34 cycles after the divide start.
REQ-041 Build without MULTDIV_DIV_EN, then pulse ctrl_DIV: data_resultRDY on the next cycle with result 0 and exception 1.
